// File: rtl/tri_bus_pkg.sv
// Shared types and sizing helpers for the tri_bus_arbiter slice.
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_e;

   localparam int NREQ_DEF    = 4;
   localparam int DW_DEF      = 54;
   localparam int MAXHOLD_DEF = 15;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick
   import tri_bus_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         pick,
   output logic                    any
);

   always_comb begin
      pick = '0;
      any  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && req[idx]) begin
            pick[idx] = 1'b1;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin single-owner sequencer for a shared 4-state bus with a turnaround cycle.
// Optional XZ_CHECK_EN adds a sticky x/z detector on the owner's data.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int DW      = DW_DEF,
   parameter int MAXHOLD = MAXHOLD_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          last,
   input  logic [NREQ-1:0][DW-1:0]  din,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          oe,
   output logic [DW-1:0]            bus_out,
   output logic                     bus_vld,
   output logic                     timeout_err,
   output logic                     xz_err
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = clog2(MAXHOLD + 1);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   own_q, own_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            tmo_q, tmo_d;

   logic [NREQ-1:0] pick;
   logic            any;
   logic [PW-1:0]   pick_idx;
   logic            own_req, own_last, hold_full;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (req),
      .ptr  (ptr_q),
      .pick (pick),
      .any  (any)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (pick[i]) pick_idx = PW'(i);
   end

   assign own_req   = req[own_q];
   assign own_last  = last[own_q];
   assign bus_vld   = (state_q == GRANT) && own_req;
   assign hold_full = (cnt_q + CW'(1)) == CW'(MAXHOLD);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) begin
               gnt_d   = pick;
               own_d   = pick_idx;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!own_req || own_last || hold_full) begin
               state_d = TURN;
               gnt_d   = '0;
               ptr_d   = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);
               // Timeout only when the cap, not last or a drop, ended the tenure.
               tmo_d   = own_req && !own_last && hold_full;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         own_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign gnt         = gnt_q;
   assign oe          = (state_q == GRANT) ? gnt_q : '0;
   assign bus_out     = bus_vld ? din[own_q] : {DW{1'bz}};
   assign timeout_err = tmo_q;

`ifdef XZ_CHECK_EN
   logic xz_q, xz_d;

   always_comb begin
      xz_d = xz_q;
      if (bus_vld && ((^din[own_q]) === 1'bx)) xz_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) xz_q <= 1'b0;
      else     xz_q <= xz_d;
   end

   assign xz_err = xz_q;
`else
   assign xz_err = 1'b0;
`endif

endmodule
